// File: rtl/roi_crop_pkg.sv
// Shared widths, stride encodings and sideband bundle for the ROI crop stream.
package roi_crop_pkg;

    localparam logic [1:0] STRIDE_LOG2_1 = 2'd0;
    localparam logic [1:0] STRIDE_LOG2_2 = 2'd1;
    localparam logic [1:0] STRIDE_LOG2_4 = 2'd2;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } sideband_t;

    localparam int SIDEBAND_W = $bits(sideband_t);

    // Never return a zero width, so degenerate 1-pixel frames still elaborate.
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int coord_w(input int extent);
        return clog2_min1(extent);
    endfunction

    function automatic int size_w(input int extent);
        return clog2_min1(extent + 1);
    endfunction

    function automatic logic [1:0] norm_stride(input logic [1:0] sl);
        return (sl == 2'd3) ? STRIDE_LOG2_4 : sl;
    endfunction

    function automatic logic [2:0] stride_step(input logic [1:0] sl);
        case (sl)
            STRIDE_LOG2_1: return 3'd1;
            STRIDE_LOG2_2: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] stride_mask(input logic [1:0] sl);
        case (sl)
            STRIDE_LOG2_1: return 3'd0;
            STRIDE_LOG2_2: return 3'd1;
            default:       return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/roi_skid_buffer.sv
// Two-entry skid buffer with a registered push-side ready.
module roi_skid_buffer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              ready_q, ready_d;
    logic              do_push, do_pop;

    assign do_push    = push_valid && ready_q;
    assign do_pop     = pop_ready && (count_q != 2'd0);
    assign push_ready = ready_q;
    assign pop_valid  = (count_q != 2'd0);
    assign pop_data   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready reflects occupancy after this cycle's traffic, so it never waits on pop_ready combinationally.
        ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            mem_q[gi] <= mem_d[gi];
        end
    end

endmodule

// File: rtl/roi_crop_stream.sv
// Crops and decimates a raster pixel stream to a per-frame window, tagging sof/eol/eof.
module roi_crop_stream
    import roi_crop_pkg::*;
#(
    parameter  int PIXEL_BIT_WIDTH = 12,
    parameter  int CHANNELS        = 1,
    parameter  int IN_ROWS         = 40,
    parameter  int IN_COLS         = 40,
    localparam int XW              = coord_w(IN_COLS),
    localparam int YW              = coord_w(IN_ROWS),
    localparam int WW              = size_w(IN_COLS),
    localparam int HW              = size_w(IN_ROWS),
    localparam int DW              = PIXEL_BIT_WIDTH * CHANNELS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] cfg_x0,
    input  logic [YW-1:0] cfg_y0,
    input  logic [WW-1:0] cfg_w,
    input  logic [HW-1:0] cfg_h,
    input  logic [1:0]    cfg_stride_log2,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          frame_done
);

    // Extra headroom so x + step and x0 + w never wrap.
    localparam int XE = WW + 3;
    localparam int YE = HW + 3;
    localparam logic [XW-1:0] X_LAST  = XW'(IN_COLS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IN_ROWS - 1);
    localparam logic [XE-1:0] X_LIMIT = XE'(IN_COLS);
    localparam logic [YE-1:0] Y_LIMIT = YE'(IN_ROWS);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [YW-1:0] y0_q, y0_d;
    logic [WW-1:0] x_end_q, x_end_d;
    logic [HW-1:0] y_end_q, y_end_d;
    logic [1:0]    sl_q, sl_d;
    logic          kept_seen_q, kept_seen_d;
    logic          frame_done_q, frame_done_d;

    logic [XE-1:0] live_x_sum;
    logic [YE-1:0] live_y_sum;
    logic [WW-1:0] live_x_end;
    logic [HW-1:0] live_y_end;
    logic [1:0]    live_sl;

    logic          at_origin, accept, push, keep, last_pos, shadow_load;
    logic [XW-1:0] eff_x0;
    logic [YW-1:0] eff_y0;
    logic [WW-1:0] eff_x_end;
    logic [HW-1:0] eff_y_end;
    logic [1:0]    eff_sl;
    logic [XE-1:0] x_ext, x0_ext, x_end_ext, dx;
    logic [YE-1:0] y_ext, y0_ext, y_end_ext, dy;
    logic          x_hit, y_hit, x_last_kept, y_last_kept;
    sideband_t     sb_in, sb_out;
    logic [DW+SIDEBAND_W-1:0] skid_out;

    always_comb begin
        live_x_sum = XE'(cfg_x0) + XE'(cfg_w);
        live_y_sum = YE'(cfg_y0) + YE'(cfg_h);
        live_x_end = (live_x_sum > X_LIMIT) ? WW'(X_LIMIT) : WW'(live_x_sum);
        live_y_end = (live_y_sum > Y_LIMIT) ? HW'(Y_LIMIT) : HW'(live_y_sum);
        live_sl    = norm_stride(cfg_stride_log2);
    end

    assign at_origin = (x_q == '0) && (y_q == '0);
    assign accept    = in_valid && in_ready;
    assign last_pos  = (x_q == X_LAST) && (y_q == Y_LAST);

    // The origin beat is judged against the live config it is about to latch.
    always_comb begin
        eff_x0    = at_origin ? cfg_x0     : x0_q;
        eff_y0    = at_origin ? cfg_y0     : y0_q;
        eff_x_end = at_origin ? live_x_end : x_end_q;
        eff_y_end = at_origin ? live_y_end : y_end_q;
        eff_sl    = at_origin ? live_sl    : sl_q;

        x_ext     = XE'(x_q);
        x0_ext    = XE'(eff_x0);
        x_end_ext = XE'(eff_x_end);
        y_ext     = YE'(y_q);
        y0_ext    = YE'(eff_y0);
        y_end_ext = YE'(eff_y_end);
        dx        = x_ext - x0_ext;
        dy        = y_ext - y0_ext;

        x_hit = (x_ext >= x0_ext) && (x_ext < x_end_ext)
                && ((dx & XE'(stride_mask(eff_sl))) == '0);
        y_hit = (y_ext >= y0_ext) && (y_ext < y_end_ext)
                && ((dy & YE'(stride_mask(eff_sl))) == '0);
        x_last_kept = (x_ext + XE'(stride_step(eff_sl))) >= x_end_ext;
        y_last_kept = (y_ext + YE'(stride_step(eff_sl))) >= y_end_ext;
        keep = x_hit && y_hit;

        sb_in.sof = !kept_seen_q;
        sb_in.eol = x_last_kept;
        sb_in.eof = x_last_kept && y_last_kept;
    end

    assign push = accept && keep;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        shadow_load = reset || (accept && at_origin);
        x0_d    = shadow_load ? cfg_x0     : x0_q;
        y0_d    = shadow_load ? cfg_y0     : y0_q;
        x_end_d = shadow_load ? live_x_end : x_end_q;
        y_end_d = shadow_load ? live_y_end : y_end_q;
        sl_d    = shadow_load ? live_sl    : sl_q;

        kept_seen_d = kept_seen_q;
        if (accept && last_pos) begin
            kept_seen_d = 1'b0;
        end else if (push) begin
            kept_seen_d = 1'b1;
        end
        frame_done_d = accept && last_pos;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            kept_seen_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            kept_seen_q  <= kept_seen_d;
            frame_done_q <= frame_done_d;
        end
        x0_q    <= x0_d;
        y0_q    <= y0_d;
        x_end_q <= x_end_d;
        y_end_q <= y_end_d;
        sl_q    <= sl_d;
    end

    roi_skid_buffer #(
        .DATA_W (DW + SIDEBAND_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push),
        .push_data  ({sb_in, in_data}),
        .push_ready (in_ready),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (skid_out)
    );

    assign sb_out     = skid_out[DW +: SIDEBAND_W];
    assign out_data   = skid_out[DW-1:0];
    assign out_sof    = sb_out.sof;
    assign out_eol    = sb_out.eol;
    assign out_eof    = sb_out.eof;
    assign frame_done = frame_done_q;

endmodule
